// File: rtl/thread_ready_queue.sv
// thread_ready_queue: circular FIFO of runnable thread IDs feeding the Scheduler.
// Publishes depth plus the first two queued IDs, pops the head when the
// Scheduler requests exactly that ID, and accepts re-entering threads through
// an enqueue port with overflow and duplicate rejection (sticky error flags).
module thread_ready_queue #(
    parameter int ID_W       = 4,
    parameter int DEPTH      = 2**ID_W - 1,
    parameter int INIT_COUNT = DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enq_valid,
    input  logic [ID_W-1:0] enq_id,
    input  logic            requesting_thread,
    input  logic [ID_W-1:0] requested_thread_id,
    output logic [ID_W-1:0] waiting_thread_count,
    output logic [ID_W-1:0] waiting_next_id,
    output logic [ID_W-1:0] waiting_next_id2,
    output logic            overflow_err,
    output logic            dup_err
);
    localparam logic [ID_W-1:0] LAST_PTR  = ID_W'(DEPTH - 1);
    localparam logic [ID_W-1:0] DEPTH_C   = ID_W'(DEPTH);
    localparam logic [ID_W-1:0] INIT_C    = ID_W'(INIT_COUNT);
    localparam logic [ID_W-1:0] INIT_TAIL = ID_W'(INIT_COUNT % DEPTH);
    localparam int              NUM_IDS   = 2**ID_W;

    logic [ID_W-1:0]    r_mem [DEPTH];
    logic [ID_W-1:0]    r_head;
    logic [ID_W-1:0]    r_tail;
    logic [ID_W-1:0]    r_count;
    logic [NUM_IDS-1:0] r_bitmap;
    logic               r_overflow;
    logic               r_dup;

    logic [ID_W-1:0]    w_head_id;
    logic [ID_W-1:0]    w_head_nxt;
    logic [ID_W-1:0]    w_tail_nxt;
    logic               w_pop;
    logic               w_room;
    logic               w_dup;
    logic               w_accept;

    // Pointer increment wrapping at the last slot (DEPTH need not be a power of 2)
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ID_W'(1);
    endfunction

    // Pop / enqueue decision; an enqueue of the ID being popped is not a duplicate
    always_comb begin
        w_head_id  = r_mem[r_head];
        w_head_nxt = wrap_inc(r_head);
        w_tail_nxt = wrap_inc(r_tail);
        w_pop      = requesting_thread && (r_count != '0) && (requested_thread_id == w_head_id);
        w_room     = (r_count != DEPTH_C) || w_pop;
        w_dup      = r_bitmap[enq_id] && !(w_pop && (enq_id == w_head_id));
        w_accept   = enq_valid && w_room && !w_dup;
    end

    // Pointers, count and sticky error flags; a full queue is reported before a duplicate
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= INIT_TAIL;
            r_count    <= INIT_C;
            r_overflow <= 1'b0;
            r_dup      <= 1'b0;
        end else begin
            if (w_pop)
                r_head <= w_head_nxt;
            if (w_accept)
                r_tail <= w_tail_nxt;
            if (w_pop && !w_accept)
                r_count <= r_count - ID_W'(1);
            else if (w_accept && !w_pop)
                r_count <= r_count + ID_W'(1);
            if (enq_valid && !w_room)
                r_overflow <= 1'b1;
            else if (enq_valid && w_dup)
                r_dup <= 1'b1;
        end
    end

    // Queue storage, preloaded with IDs 0..INIT_COUNT-1 on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= (i < INIT_COUNT) ? ID_W'(i) : '0;
        end else if (w_accept) begin
            r_mem[r_tail] <= enq_id;
        end
    end

    // Occupancy bitmap; the set on enqueue is ordered after the clear on pop so a re-queued ID stays marked
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IDS; i++)
                r_bitmap[i] <= (i < INIT_COUNT);
        end else begin
            if (w_pop)
                r_bitmap[w_head_id] <= 1'b0;
            if (w_accept)
                r_bitmap[enq_id] <= 1'b1;
        end
    end

    // Outputs derived from registered state only
    always_comb begin
        waiting_thread_count = r_count;
        waiting_next_id      = (r_count != '0) ? w_head_id : '0;
        waiting_next_id2     = (r_count > ID_W'(1)) ? r_mem[w_head_nxt] : '0;
        overflow_err         = r_overflow;
        dup_err              = r_dup;
    end

endmodule

// File: tb/tb_thread_ready_queue.sv
// Testbench for thread_ready_queue: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_thread_ready_queue;
    localparam int DEPTH = 15;
    localparam int INIT  = 15;

    logic       clk;
    logic       rst;
    logic       enq_valid;
    logic [3:0] enq_id;
    logic       requesting_thread;
    logic [3:0] requested_thread_id;
    logic [3:0] waiting_thread_count;
    logic [3:0] waiting_next_id;
    logic [3:0] waiting_next_id2;
    logic       overflow_err;
    logic       dup_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: ordered list of queued IDs plus sticky error bits
    int q[$];
    bit m_ovf;
    bit m_dup;

    thread_ready_queue dut (
        .clk                  (clk),
        .rst                  (rst),
        .enq_valid            (enq_valid),
        .enq_id               (enq_id),
        .requesting_thread    (requesting_thread),
        .requested_thread_id  (requested_thread_id),
        .waiting_thread_count (waiting_thread_count),
        .waiting_next_id      (waiting_next_id),
        .waiting_next_id2     (waiting_next_id2),
        .overflow_err         (overflow_err),
        .dup_err              (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic bit in_q(input int id);
        foreach (q[i]) if (q[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int head_or(input int dflt);
        return (q.size() > 0) ? q[0] : dflt;
    endfunction

    task automatic model_step(input bit ev, input int eid, input bit rq, input int rid, input bit rs);
        bit pop, room, dupl;
        if (rs) begin
            q.delete();
            for (int i = 0; i < INIT; i++) q.push_back(i);
            m_ovf = 0;
            m_dup = 0;
            return;
        end
        pop  = rq && q.size() > 0 && q[0] == rid;
        room = (q.size() < DEPTH) || pop;
        dupl = in_q(eid) && !(pop && q[0] == eid);
        if (pop) void'(q.pop_front());
        if (ev) begin
            if (!room)     m_ovf = 1;
            else if (dupl) m_dup = 1;
            else           q.push_back(eid);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(waiting_thread_count), 32'(q.size()));
        chk({tag, ".next"},  32'(waiting_next_id),  32'((q.size() > 0) ? q[0] : 0));
        chk({tag, ".next2"}, 32'(waiting_next_id2), 32'((q.size() > 1) ? q[1] : 0));
        chk({tag, ".ovf"},   32'(overflow_err), 32'(m_ovf));
        chk({tag, ".dup"},   32'(dup_err),      32'(m_dup));
    endtask

    // One clock: drive inputs, advance model, sample outputs 1 time unit after the edge
    task automatic cycle(input string tag, input bit ev, input int eid, input bit rq, input int rid, input bit rs);
        enq_valid           = ev;
        enq_id              = 4'(eid);
        requesting_thread   = rq;
        requested_thread_id = 4'(rid);
        rst                 = rs;
        model_step(ev, eid, rq, rid, rs);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        enq_valid = 0; enq_id = 0; requesting_thread = 0; requested_thread_id = 0; rst = 1;
        m_ovf = 0; m_dup = 0;

        // Reset preload
        cycle("reset", 0, 0, 0, 0, 1);
        chk("reset.count_const", 32'(waiting_thread_count), 15);
        chk("reset.next_const",  32'(waiting_next_id), 0);
        chk("reset.next2_const", 32'(waiting_next_id2), 1);

        // Back-to-back pops 0,1,2
        cycle("pop0", 0, 0, 1, 0, 0);
        cycle("pop1", 0, 0, 1, 1, 0);
        cycle("pop2", 0, 0, 1, 2, 0);
        chk("pop2.count_const", 32'(waiting_thread_count), 12);
        chk("pop2.next_const",  32'(waiting_next_id), 3);
        chk("pop2.next2_const", 32'(waiting_next_id2), 4);

        // Non-head request is ignored
        cycle("nonhead", 0, 0, 1, 9, 0);

        // Fill to capacity, overflow, then enqueue alongside a head pop
        cycle("fill15", 1, 15, 0, 0, 0);
        cycle("fill0",  1, 0,  0, 0, 0);
        cycle("fill1",  1, 1,  0, 0, 0);
        cycle("ovf",    1, 3,  0, 0, 0);
        chk("ovf.flag_const", 32'(overflow_err), 1);
        cycle("fullpop", 1, 3, 1, 3, 0);
        chk("fullpop.count_const", 32'(waiting_thread_count), 15);

        // Duplicate rejection, then drain and enqueue into empty
        cycle("popfor_dup", 0, 0, 1, head_or(0), 0);
        cycle("dup", 1, 5, 0, 0, 0);
        chk("dup.flag_const", 32'(dup_err), 1);
        for (int i = 0; i < 20 && q.size() > 0; i++)
            cycle("drain", 0, 0, 1, head_or(0), 0);
        cycle("enq_empty", 1, 7, 0, 0, 0);
        chk("enq_empty.next2_const", 32'(waiting_next_id2), 0);

        // Wrap-around: pop head and re-enqueue it every cycle
        cycle("reset2", 0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            int h;
            h = head_or(0);
            cycle("wrap", 1, h, 1, h, 0);
        end
        cycle("reset_mid", 1, 4, 1, head_or(0), 1);

        // Randomized traffic, requests biased toward the current head
        for (int i = 0; i < 600; i++) begin
            bit ev, rq, rs;
            int eid, rid;
            ev  = ($urandom_range(0, 99) < 60);
            eid = $urandom_range(0, 15);
            rq  = ($urandom_range(0, 99) < 55);
            rid = ($urandom_range(0, 99) < 70) ? head_or(0) : $urandom_range(0, 15);
            rs  = ($urandom_range(0, 199) == 0);
            cycle("rand", ev, eid, rq, rid, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
